ex_mdu_ctrl: RTL and testbench
==============================

Name: ex_mdu_ctrl

Overview:
- Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting beside the single-cycle ex stage.
- Accepts an M-type op from id_ex and raises a hold that freezes pc, if_id and id_ex.
- Runs an iterative radix-2 shift-add / shift-subtract on operand magnitudes, then writes back through the regs write port.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 5, iteration counter width (XLEN = 2^CNT_W)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  valid M-type op in id_ex this cycle (opcode INST_TYPE_R_M, func7 = 7'b0000001)
- func3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1_i  in  XLEN  rs1 value
- op2_i  in  XLEN  rs2 value
- rd_addr_i  in  5  destination register
- flush_i  in  1  branch/jump cancel from ctrl
- hold_o  out  1  stall request to ctrl
- busy_o  out  1  sequencer not IDLE
- rd_wdata_o  out  XLEN  result
- rd_waddr_o  out  5  result register
- reg_wen_o  out  1  one-cycle write strobe

Behaviour:
- Reset (rst=0, async): state=IDLE; counter, operand/accumulator registers, rd_wdata_o, rd_waddr_o, reg_wen_o all 0. hold_o=0, busy_o=0.
- States:
  - IDLE: on start_i & ~flush_i, latch func3, rd_addr, operands and sign flags; operands are converted to magnitudes where signed (MULH: both; MULHSU: op1 only; DIV/REM: both); counter=0.
    - Next state is FIN if the op is special (see below), else CALC.
  - CALC: one bit per cycle, counter 0..31.
    - Multiply: if multiplier LSB, add multiplicand to high half of 64-bit accumulator; shift right 1.
    - Divide: shift {rem,quot} left 1; if rem >= divisor, subtract and set quot LSB.
    - At counter==31 go to FIN.
  - FIN: apply sign correction, register the result onto rd_wdata_o/rd_waddr_o, pulse reg_wen_o for exactly one cycle, return to IDLE.
- Sign rules:
  - Product is negated if the operand signs differ (MULHSU: op1 sign only).
  - Quotient is negated if the signs differ; remainder takes the dividend sign.
  - MUL returns the low 32 bits; MULH* return the high 32 bits.
- Special ops, which skip CALC:
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- hold_o (combinational): (IDLE & start_i & ~flush_i) | CALC. It is 0 in FIN, so the pipeline advances in the writeback cycle.
- busy_o = state != IDLE.
- Latency:
  - Start sampled at edge T; normal ops write at edge T+33 (reg_wen_o high during cycle T+33).
  - Special ops write at T+1.
- rd_addr_i == 0: the sequence runs fully, but reg_wen_o is suppressed.
- flush_i:
  - In any state, the next state is IDLE.
  - No reg_wen_o pulse; hold_o is forced 0 in the same cycle.
  - flush_i together with start_i in IDLE: flush wins, nothing starts.
- start_i while not IDLE is ignored (id_ex is frozen, so it is legal to remain asserted).
- Arithmetic: the divider's remainder register is XLEN+1 bits wide for the compare; all negation is two's complement modulo 2^XLEN.

Test Plan:
- DIVU op1=100, op2=7, rd=5, start at T -> hold_o high from T through T+32; at T+33 reg_wen_o=1, rd_waddr_o=5, rd_wdata_o=14. Repeat with REMU -> 2.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIVU op2=0 -> 0xFFFFFFFF at T+1; REM op1=0x1234, op2=0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1, hold_o high only in cycle T.
- op1=op2=0xFFFFFFFF: MUL -> 0x00000001, MULH -> 0x00000000, MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF.
- Flush: start DIVU, assert flush_i at T+10 -> busy_o=0 at T+11, no reg_wen_o through T+40. Same-cycle start+flush -> state stays IDLE, hold_o=0.
- Reset: deassert rst mid-CALC at T+15 (asynchronous) -> outputs 0 immediately, IDLE. Release, then MUL 3*5 with rd=0 -> full latency, reg_wen_o never asserted.

Source files
------------

// File: rtl/ex_mdu_ctrl_if.sv
// Handshake between the id_ex/ex stage and the RV32M sequencer: op request in,
// stall/busy status and register writeback out.
interface ex_mdu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      func3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            hold_o;
    logic            busy_o;
    logic [XLEN-1:0] rd_wdata_o;
    logic [4:0]      rd_waddr_o;
    logic            reg_wen_o;

    // Pipeline side: issues ops and flushes, observes stall and writeback.
    modport master (
        output start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  hold_o, busy_o, rd_wdata_o, rd_waddr_o, reg_wen_o
    );

    // Sequencer side.
    modport slave (
        input  start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
        output hold_o, busy_o, rd_wdata_o, rd_waddr_o, reg_wen_o
    );
endinterface

// File: rtl/ex_mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add / shift-subtract on
// operand magnitudes, sign fix-up at the end, one-cycle writeback strobe.
module ex_mdu_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    ex_mdu_ctrl_if.slave mdu_if
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          rd_q, rd_d;
    logic                sgn1_q, sgn1_d;
    logic                sgn2_q, sgn2_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [4:0]          waddr_q, waddr_d;
    logic                wen_q, wen_d;
    logic                hold;

    // ---------------- request decode ----------------
    logic [2:0]      f3_in;
    logic [XLEN-1:0] op1_in, op2_in;
    logic            op1_signed, op2_signed;
    logic            sgn1_in, sgn2_in;
    logic [XLEN-1:0] mag1_in, mag2_in;
    logic            div_zero, div_ovf, is_special;
    logic [XLEN-1:0] spec_val;
    logic            launch;

    assign f3_in  = mdu_if.func3_i;
    assign op1_in = mdu_if.op1_i;
    assign op2_in = mdu_if.op2_i;

    assign op1_signed = (f3_in == F_MULH) || (f3_in == F_MULHSU) ||
                        (f3_in == F_DIV)  || (f3_in == F_REM);
    assign op2_signed = (f3_in == F_MULH) || (f3_in == F_DIV) || (f3_in == F_REM);

    assign sgn1_in = op1_signed & op1_in[XLEN-1];
    assign sgn2_in = op2_signed & op2_in[XLEN-1];
    assign mag1_in = sgn1_in ? -op1_in : op1_in;
    assign mag2_in = sgn2_in ? -op2_in : op2_in;

    // Divide-by-zero and signed overflow have fixed results, so they bypass CALC.
    assign div_zero   = (op2_in == '0);
    assign div_ovf    = ((f3_in == F_DIV) || (f3_in == F_REM)) &&
                        (op1_in == {1'b1, {(XLEN-1){1'b0}}}) && (op2_in == '1);
    assign is_special = f3_in[2] & (div_zero | div_ovf);

    always_comb begin
        spec_val = '0;
        if (div_zero)
            spec_val = f3_in[1] ? op1_in : '1;
        else
            spec_val = f3_in[1] ? '0 : op1_in;
    end

    assign launch = mdu_if.start_i & ~mdu_if.flush_i;

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    // Partial remainder is compared at XLEN+1 bits; after a successful subtract it
    // is always below the divisor, so XLEN bits suffice to hold it.
    assign div_sh   = {rem_q, acc_q[XLEN-1]};
    assign div_ge   = (div_sh >= {1'b0, opb_q});
    assign div_diff = div_sh[XLEN-1:0] - opb_q;

    // ---------------- sign fix-up ----------------
    logic              res_neg;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd;
    logic [XLEN-1:0]   result;

    assign res_neg = sgn1_q ^ sgn2_q;
    assign prod    = res_neg ? -acc_q : acc_q;
    assign quo     = res_neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rmd     = sgn1_q ? -rem_q : rem_q;

    always_comb begin
        result = '0;
        if (spec_q) begin
            result = acc_q[XLEN-1:0];
        end else begin
            unique case (f3_q)
                F_MUL:                     result = prod[XLEN-1:0];
                F_MULH, F_MULHSU, F_MULHU: result = prod[2*XLEN-1:XLEN];
                F_DIV, F_DIVU:             result = quo;
                F_REM, F_REMU:             result = rmd;
                default:                   result = '0;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        sgn1_d  = sgn1_q;
        sgn2_d  = sgn2_q;
        spec_d  = spec_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        wen_d   = 1'b0;
        hold    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    hold   = 1'b1;
                    f3_d   = f3_in;
                    rd_d   = mdu_if.rd_addr_i;
                    sgn1_d = sgn1_in;
                    sgn2_d = sgn2_in;
                    spec_d = is_special;
                    cnt_d  = '0;
                    rem_d  = '0;
                    // Divide: dividend shifts out of the low half as quotient shifts in.
                    // Multiply: multiplier sits in the low half and is consumed LSB first.
                    opb_d  = f3_in[2] ? mag2_in : mag1_in;
                    if (is_special)
                        acc_d = {{XLEN{1'b0}}, spec_val};
                    else
                        acc_d = {{XLEN{1'b0}}, (f3_in[2] ? mag1_in : mag2_in)};
                    state_d = is_special ? FIN : CALC;
                end
            end
            CALC: begin
                hold  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (f3_q[2]) begin
                    rem_d = div_ge ? div_diff : div_sh[XLEN-1:0];
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == '1)
                    state_d = FIN;
            end
            FIN: begin
                if (!mdu_if.flush_i) begin
                    wdata_d = result;
                    waddr_d = rd_q;
                    wen_d   = (rd_q != 5'd0);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mdu_if.flush_i) begin
            state_d = IDLE;
            hold    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            sgn1_q  <= 1'b0;
            sgn2_q  <= 1'b0;
            spec_q  <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            sgn1_q  <= sgn1_d;
            sgn2_q  <= sgn2_d;
            spec_q  <= spec_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            wen_q   <= wen_d;
        end
    end

    assign mdu_if.hold_o     = hold;
    assign mdu_if.busy_o     = (state_q != IDLE);
    assign mdu_if.rd_wdata_o = wdata_q;
    assign mdu_if.rd_waddr_o = waddr_q;
    assign mdu_if.reg_wen_o  = wen_q;

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Bench for ex_mdu_ctrl: reference results from plain 64-bit arithmetic, a timing
// model of busy/hold/writeback windows, and a per-cycle compare against the DUT.
module tb_ex_mdu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_mdu_ctrl_if #(.XLEN(32)) bus ();

    ex_mdu_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .mdu_if (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected-behaviour window of the op in flight, in posedge numbers.
    int          m_lo      = 0;
    int          m_busy_hi = -1;
    int          m_hold_hi = -1;
    int          m_due     = -1;
    bit          m_wen     = 1'b0;
    logic [31:0] m_data    = '0;
    logic [4:0]  m_addr    = '0;
    bit          chk_en    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit special_op(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Per-cycle compare of status and writeback against the model.
    bit e_busy, e_hold, e_wen;
    always @(negedge clk) begin
        if (chk_en && rst) begin
            e_busy = (cyc >= m_lo) && (cyc <= m_busy_hi);
            e_hold = !bus.flush_i && ((bus.start_i && !e_busy) ||
                                      ((cyc >= m_lo) && (cyc <= m_hold_hi)));
            e_wen  = m_wen && (cyc == m_due);
            chk("busy_o", bus.busy_o, e_busy);
            chk("hold_o", bus.hold_o, e_hold);
            chk("reg_wen_o", bus.reg_wen_o, e_wen);
            if (e_wen) begin
                chk("rd_wdata_o", bus.rd_wdata_o, m_data);
                chk("rd_waddr_o", bus.rd_waddr_o, m_addr);
            end
        end
    end

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] hand, input string name);
        logic [31:0] r;
        bit          sp;
        int          t;
        r  = ref_result(f3, a, b);
        chk({name, " model"}, r, hand);
        sp = special_op(f3, a, b);
        @(negedge clk); #1;
        bus.start_i   = 1'b1;
        bus.func3_i   = f3;
        bus.op1_i     = a;
        bus.op2_i     = b;
        bus.rd_addr_i = rd;
        #1 chk({name, " hold at start"}, bus.hold_o, 1'b1);
        @(posedge clk); #1;
        t = cyc;
        bus.start_i = 1'b0;
        m_lo      = t;
        m_busy_hi = sp ? t : t + 32;
        m_hold_hi = sp ? t - 1 : t + 31;
        m_due     = m_busy_hi + 1;
        m_wen     = (rd != 5'd0);
        m_data    = r;
        m_addr    = rd;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] hand, input string name);
        launch(f3, a, b, rd, hand, name);
        while (cyc < m_due + 2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i   = 1'b0;
        bus.func3_i   = 3'd0;
        bus.op1_i     = '0;
        bus.op2_i     = '0;
        bus.rd_addr_i = '0;
        bus.flush_i   = 1'b0;

        #1 rst = 1'b0;
        #1;
        chk("reset busy_o", bus.busy_o, 1'b0);
        chk("reset hold_o", bus.hold_o, 1'b0);
        chk("reset reg_wen_o", bus.reg_wen_o, 1'b0);
        chk("reset rd_wdata_o", bus.rd_wdata_o, 32'h0);
        chk("reset rd_waddr_o", bus.rd_waddr_o, 5'd0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);

        run_op(3'd5, 32'd100, 32'd7, 5'd5, 32'd14, "DIVU 100/7");
        run_op(3'd7, 32'd100, 32'd7, 5'd5, 32'd2, "REMU 100%7");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, "REM -7%2");
        run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, "DIV 7/-2");
        run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, "REM 7%-2");
        run_op(3'd5, 32'd55, 32'd0, 5'd8, 32'hFFFF_FFFF, "DIVU by 0");
        run_op(3'd6, 32'h1234, 32'd0, 5'd9, 32'h1234, "REM by 0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, "DIV ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, "REM ovf");
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h1, "MUL -1*-1");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0, "MULH -1*-1");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE, "MULHU max*max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFF, "MULHSU -1*max");
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFEB, "MUL 7*-3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd16, 32'h4000_0000, "MULH min*min");

        // Flush mid-CALC: sequencer drops the op with no writeback.
        launch(3'd5, 32'd1000, 32'd3, 5'd17, 32'd333, "DIVU flushed");
        while (cyc != m_lo + 10) @(negedge clk);
        #1 bus.flush_i = 1'b1;
        #1 chk("hold_o under flush", bus.hold_o, 1'b0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        m_busy_hi = m_lo + 10;
        m_hold_hi = m_lo + 10;
        m_wen     = 1'b0;
        while (cyc < m_lo + 41) @(posedge clk);

        // Start and flush together: nothing starts.
        @(negedge clk); #1;
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.func3_i = 3'd5;
        bus.op1_i   = 32'd9;
        bus.op2_i   = 32'd2;
        bus.rd_addr_i = 5'd3;
        #1 chk("hold_o start+flush", bus.hold_o, 1'b0);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("busy_o after start+flush", bus.busy_o, 1'b0);
        repeat (3) @(posedge clk);

        // Asynchronous reset mid-CALC.
        launch(3'd5, 32'd100, 32'd7, 5'd5, 32'd14, "DIVU reset");
        while (cyc != m_lo + 15) @(negedge clk);
        #2 rst = 1'b0;
        m_busy_hi = -1;
        m_hold_hi = -1;
        m_due     = -1;
        m_wen     = 1'b0;
        #1;
        chk("async rst busy_o", bus.busy_o, 1'b0);
        chk("async rst hold_o", bus.hold_o, 1'b0);
        chk("async rst reg_wen_o", bus.reg_wen_o, 1'b0);
        chk("async rst rd_wdata_o", bus.rd_wdata_o, 32'h0);
        chk("async rst rd_waddr_o", bus.rd_waddr_o, 5'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);

        // rd = x0: full latency, writeback strobe suppressed.
        run_op(3'd0, 32'd3, 32'd5, 5'd0, 32'd15, "MUL 3*5 rd0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
